// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Four-requester round-robin arbiter for one shared resource. The winner is
//   held as a 2-bit index. It is decoded to a one-hot grant, or to a one-cold
//   grant when active_low is set. A grant is held until the requester drops
//   its req line or MAX_HOLD cycles have elapsed. After every grant there is
//   one idle cycle.
//
//   Ports:
//     clock       rising-edge clock for all state
//     reset       asynchronous, active-high reset
//     req[3:0]    request lines; req[i] high = requester i wants or holds it
//     active_low  grant polarity (0 = one-hot, 1 = one-cold); combinational
//     grant[3:0]  decoded grant from registered state and active_low
//     grant_idx   index of the current or last winner (registered)
//     grant_valid high while a grant is held (registered)
//     timeout     one-cycle pulse when MAX_HOLD revokes a grant (registered)
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       active_low,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  // When MAX_HOLD is 0 there is no limit. HOLD_LAST is then unused.
  localparam bit         LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = LIMIT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       to_q, to_d;
  logic [7:0] cnt_q, cnt_d;

  // Rotating-priority pick. The scan runs last+1 .. last+4 (mod 4). This
  // means the previous winner is considered last.
  logic [1:0] pick;
  logic       pick_ok;
  always_comb begin
    logic [1:0] cand;
    pick    = last_q;
    pick_ok = 1'b0;
    cand    = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = BUSY;
          idx_d   = pick;
          last_d  = pick;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (LIMIT_EN && cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          valid_d = 1'b0;
          to_d    = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          // When there is no limit, the counter saturates instead of wrapping.
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'b00;
      last_q  <= 2'b11;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // 2-to-4 decode with polarity select.
  always_comb begin
    grant = 4'b0000;
    for (int i = 0; i < 4; i++)
      grant[i] = (valid_q && idx_q == 2'(i)) ^ active_low;
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter. There are two instances: the default MAX_HOLD=8
// build and a MAX_HOLD=0 build. Each one has its own reset, so the unlimited
// build can hold one grant across the whole directed phase. A cycle-level
// behavioural model per instance is checked against the DUT every cycle.
// The directed scenarios also carry hand-computed literal expectations.
module tb_rr_decode_arbiter;
  logic       clk, rst, rst0, al;
  logic [3:0] req8, req0;
  logic [3:0] g8, g0;
  logic [1:0] idx8, idx0;
  logic       v8, v0, to8, to0;

  int total = 0;
  int bad   = 0;

  rr_decode_arbiter #(.MAX_HOLD(8)) dut8 (
    .clock(clk), .reset(rst), .req(req8), .active_low(al),
    .grant(g8), .grant_idx(idx8), .grant_valid(v8), .timeout(to8));

  rr_decode_arbiter #(.MAX_HOLD(0)) dut0 (
    .clock(clk), .reset(rst0), .req(req0), .active_low(al),
    .grant(g0), .grant_idx(idx0), .grant_valid(v0), .timeout(to0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. Index 0 is the MAX_HOLD=8 build; index 1 is the
  // MAX_HOLD=0 build. m_held is the number of cycles the current grant has
  // been visible so far.
  bit m_busy[2];
  int m_idx[2], m_last[2], m_held[2];
  bit m_to[2];

  task automatic mreset(input int d);
    m_busy[d] = 0; m_idx[d] = 0; m_last[d] = 3; m_held[d] = 0; m_to[d] = 0;
  endtask

  task automatic mstep(input int d, input logic [3:0] r, input int maxh);
    m_to[d] = 0;
    if (!m_busy[d]) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last[d] + k) % 4;
        if (r[c] && !m_busy[d]) begin
          m_busy[d] = 1; m_idx[d] = c; m_last[d] = c; m_held[d] = 1;
        end
      end
    end else if (!r[m_idx[d]]) begin
      m_busy[d] = 0;
    end else if (maxh != 0 && m_held[d] == maxh) begin
      m_busy[d] = 0; m_to[d] = 1;
    end else begin
      m_held[d]++;
    end
  endtask

  function automatic logic [3:0] exp_grant(input int d, input logic a);
    logic [3:0] g;
    g = m_busy[d] ? 4'(1 << m_idx[d]) : 4'b0000;
    return g ^ {4{a}};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) mreset(0); else mstep(0, req8, 8);
  always @(posedge clk or posedge rst0)
    if (rst0) mreset(1); else mstep(1, req0, 0);

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, well after the edge.
  initial forever begin
    @(posedge clk);
    #3;
    if (!rst) begin
      chk("m8_grant", int'(g8), int'(exp_grant(0, al)));
      chk("m8_idx", int'(idx8), m_idx[0]);
      chk("m8_valid", int'(v8), int'(m_busy[0]));
      chk("m8_timeout", int'(to8), int'(m_to[0]));
    end
    if (!rst0) begin
      chk("m0_grant", int'(g0), int'(exp_grant(1, al)));
      chk("m0_idx", int'(idx0), m_idx[1]);
      chk("m0_valid", int'(v0), int'(m_busy[1]));
      chk("m0_timeout", int'(to0), int'(m_to[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; rst0 = 1; req8 = 0; req0 = 0; al = 0;
    #11;
    chk("rst_grant", int'(g8), 0);
    chk("rst_valid", int'(v8), 0);
    chk("rst_idx", int'(idx8), 0);
    chk("rst_to", int'(to8), 0);
    #1 rst = 0; rst0 = 0;

    // Scenario 1: 0101 held. Grant 0 for 8 cycles, then the timeout pulse,
    // then grant 2. The unlimited build starts its long req[3] hold here.
    req8 = 4'b0101; req0 = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      tick(); chk("t1_grant0", int'(g8), 4'b0001);
    end
    tick();
    chk("t1_idle", int'(g8), 4'b0000);
    chk("t1_timeout", int'(to8), 1);
    chk("t1_idx_kept", int'(idx8), 0);
    tick();
    chk("t1_grant2", int'(g8), 4'b0100);
    chk("t1_idx2", int'(idx8), 2);
    chk("t1_to_clr", int'(to8), 0);
    req8 = 0;
    tick(); chk("t1_rel", int'(v8), 0);

    // Scenario 2: single requester 1 for 3 cycles.
    req8 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t2_grant", int'(g8), 4'b0010); chk("t2_to", int'(to8), 0);
    end
    req8 = 0;
    tick(); chk("t2_rel", int'(g8), 4'b0000); chk("t2_to_rel", int'(to8), 0);

    // Scenario 4: polarity, and active_low toggled mid-grant.
    al = 1; req8 = 4'b0010;
    tick(); chk("t4_grant_al", int'(g8), 4'b1101);
    tick(); chk("t4_grant_al2", int'(g8), 4'b1101);
    al = 0; #1;
    chk("t4_flip", int'(g8), 4'b0010);
    chk("t4_flip_idx", int'(idx8), 1);
    chk("t4_flip_valid", int'(v8), 1);
    al = 1; req8 = 0;
    tick(); chk("t4_idle_al", int'(g8), 4'b1111);
    al = 0;

    // Scenario 5: async reset while idx 2 is held.
    req8 = 4'b0100;
    tick(); chk("t5_idx2", int'(idx8), 2);
    req8 = 4'b1100;
    #4 rst = 1; #1;
    chk("t5_async_grant", int'(g8), 4'b0000);
    chk("t5_async_valid", int'(v8), 0);
    #1 rst = 0;
    tick();
    chk("t5_after_idx", int'(idx8), 2);
    chk("t5_after_valid", int'(v8), 1);
    req8 = 0;
    tick();

    // Scenario 3: fairness from a fresh pointer. Expected order is 0,1,2,3,0.
    #2 rst = 1; #2 rst = 0;
    req8 = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick(); chk("t3_idx", int'(idx8), n % 4); chk("t3_valid", int'(v8), 1);
      tick(); chk("t3_idx_hold", int'(idx8), n % 4);
      req8[n % 4] = 1'b0;
      tick(); chk("t3_gap", int'(v8), 0);
      req8[n % 4] = 1'b1;
    end
    req8 = 0;
    tick();

    // Scenario 6: carry the unlimited build's req[3] hold well past 256
    // cycles, while dut8 sees random traffic.
    repeat (300) begin
      tick();
      if ($urandom_range(5) == 0) req8 = 4'($urandom);
    end
    chk("t6_grant", int'(g0), 4'b1000);
    chk("t6_idx", int'(idx0), 3);
    chk("t6_to", int'(to0), 0);

    // Random traffic on both builds, plus polarity changes.
    repeat (1500) begin
      tick();
      if ($urandom_range(5) == 0) req8 = 4'($urandom);
      if ($urandom_range(5) == 0) req0 = 4'($urandom);
      if ($urandom_range(7) == 0) al = ~al;
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
